// File: rtl/rename_reg_file_if.sv
// Decoder/ROB-facing bundle of the rename register file.
// Package holds the core-wide width defaults shared by the pipeline.
package rename_rf_pkg;
    localparam int REG_WIDTH    = 5;
    localparam int VAL_WIDTH    = 32;
    localparam int ROB_ID_WIDTH = 4;
    localparam int ROB_SIZE     = 8;
endpackage

interface rename_reg_file_if #(
    parameter int REG_W = rename_rf_pkg::REG_WIDTH,
    parameter int VAL_W = rename_rf_pkg::VAL_WIDTH,
    parameter int LAB_W = rename_rf_pkg::ROB_ID_WIDTH
);
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [VAL_W-1:0] rf_val1;
    logic [VAL_W-1:0] rf_val2;
    logic [LAB_W-1:0] rf_label1;
    logic [LAB_W-1:0] rf_label2;
    logic             issue_en;
    logic [REG_W-1:0] issue_rd;
    logic [LAB_W-1:0] issue_tag;
    logic             commit_en;
    logic [REG_W-1:0] commit_rd;
    logic [VAL_W-1:0] commit_res;
    logic [LAB_W-1:0] commit_lab;
    logic             flush_in;

    modport master (
        output rs1, rs2,
        output issue_en, issue_rd, issue_tag,
        output commit_en, commit_rd, commit_res, commit_lab,
        output flush_in,
        input  rf_val1, rf_val2, rf_label1, rf_label2
    );

    modport slave (
        input  rs1, rs2,
        input  issue_en, issue_rd, issue_tag,
        input  commit_en, commit_rd, commit_res, commit_lab,
        input  flush_in,
        output rf_val1, rf_val2, rf_label1, rf_label2
    );
endinterface

// File: rtl/rename_reg_file.sv
// Architectural register file with per-register ROB rename labels.
// Optional RENAME_RF_BYPASS_EN forwards a same-cycle commit to the read ports.
module rename_reg_file #(
    parameter int REG_W = rename_rf_pkg::REG_WIDTH,
    parameter int VAL_W = rename_rf_pkg::VAL_WIDTH,
    parameter int LAB_W = rename_rf_pkg::ROB_ID_WIDTH
) (
    input logic              clk,
    input logic              rst_in,
    input logic              rdy_in,
    rename_reg_file_if.slave rf
);
    localparam int NREG = 32;

    logic [VAL_W-1:0] regs      [NREG];
    logic [LAB_W-1:0] label     [NREG];
    logic [VAL_W-1:0] regs_nxt  [NREG];
    logic [LAB_W-1:0] label_nxt [NREG];

    logic do_commit;
    logic do_issue;

    assign do_commit = rf.commit_en && (rf.commit_rd != '0);
    assign do_issue  = rf.issue_en && (rf.issue_rd != '0) && !rf.flush_in;

    // Commit first, then issue so a same-rd issue overrides the label clear.
    always_comb begin
        regs_nxt  = regs;
        label_nxt = label;
        if (do_commit) begin
            regs_nxt[rf.commit_rd] = rf.commit_res;
            if (label[rf.commit_rd] == rf.commit_lab)
                label_nxt[rf.commit_rd] = '0;
        end
        if (do_issue)
            label_nxt[rf.issue_rd] = rf.issue_tag;
        if (rf.flush_in) begin
            for (int i = 0; i < NREG; i++)
                label_nxt[i] = '0;
        end
        regs_nxt[0]  = '0;
        label_nxt[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i]  <= '0;
                label[i] <= '0;
            end
        end else if (rdy_in) begin
            regs  <= regs_nxt;
            label <= label_nxt;
        end
    end

`ifdef RENAME_RF_BYPASS_EN
    logic byp1;
    logic byp2;

    assign byp1 = rf.commit_en && (rf.rs1 != '0) &&
                  (rf.commit_rd == rf.rs1) &&
                  (label[rf.rs1] == rf.commit_lab);
    assign byp2 = rf.commit_en && (rf.rs2 != '0) &&
                  (rf.commit_rd == rf.rs2) &&
                  (label[rf.rs2] == rf.commit_lab);
`else
    logic byp1;
    logic byp2;

    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    always_comb begin
        rf.rf_val1   = regs[rf.rs1];
        rf.rf_label1 = label[rf.rs1];
        unique case (1'b1)
            (rf.rs1 == '0): begin
                rf.rf_val1   = '0;
                rf.rf_label1 = '0;
            end
            byp1: begin
                rf.rf_val1   = rf.commit_res;
                rf.rf_label1 = '0;
            end
            default: ;
        endcase
    end

    always_comb begin
        rf.rf_val2   = regs[rf.rs2];
        rf.rf_label2 = label[rf.rs2];
        unique case (1'b1)
            (rf.rs2 == '0): begin
                rf.rf_val2   = '0;
                rf.rf_label2 = '0;
            end
            byp2: begin
                rf.rf_val2   = rf.commit_res;
                rf.rf_label2 = '0;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_rename_reg_file.sv
// Self-checking bench for rename_reg_file: directed cases then a
// randomized phase against a behavioural model, via a scoreboard queue.
module tb_rename_reg_file;
    import rename_rf_pkg::*;

    localparam int RW = REG_WIDTH;
    localparam int VW = VAL_WIDTH;
    localparam int LW = ROB_ID_WIDTH;

    typedef struct {
        string         tag;
        logic [VW-1:0] val;
        logic [LW-1:0] lab;
    } exp_t;

    logic clk;
    logic rst_in;
    logic rdy_in;

    rename_reg_file_if #(.REG_W(RW), .VAL_W(VW), .LAB_W(LW)) bus ();

    rename_reg_file #(.REG_W(RW), .VAL_W(VW), .LAB_W(LW)) dut (
        .clk    (clk),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .rf     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    exp_t sbq[$];

    logic [VW-1:0] m_regs [32];
    logic [LW-1:0] m_lab  [32];

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(string t, logic [VW-1:0] v, logic [LW-1:0] l);
        exp_t e;
        e.tag = t;
        e.val = v;
        e.lab = l;
        sbq.push_back(e);
    endtask

    task automatic exp2(string t, logic [VW-1:0] v1, logic [LW-1:0] l1,
                        logic [VW-1:0] v2, logic [LW-1:0] l2);
        push({t, "_p1"}, v1, l1);
        push({t, "_p2"}, v2, l2);
    endtask

    task automatic sample();
        exp_t e;
        #1;
        if (sbq.size() < 2) begin
            chk("sb_underflow", 64'(sbq.size()), 64'd2);
        end else begin
            e = sbq.pop_front();
            chk({e.tag, "_val"}, 64'(bus.rf_val1), 64'(e.val));
            chk({e.tag, "_lab"}, 64'(bus.rf_label1), 64'(e.lab));
            e = sbq.pop_front();
            chk({e.tag, "_val"}, 64'(bus.rf_val2), 64'(e.val));
            chk({e.tag, "_lab"}, 64'(bus.rf_label2), 64'(e.lab));
        end
    endtask

    task automatic model_update();
        logic [VW-1:0] nr [32];
        logic [LW-1:0] nl [32];
        if (rst_in) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = '0;
                m_lab[i]  = '0;
            end
        end else if (rdy_in) begin
            nr = m_regs;
            nl = m_lab;
            if (bus.commit_en && bus.commit_rd != 0) begin
                nr[bus.commit_rd] = bus.commit_res;
                if (m_lab[bus.commit_rd] == bus.commit_lab)
                    nl[bus.commit_rd] = '0;
            end
            if (bus.issue_en && bus.issue_rd != 0 && !bus.flush_in)
                nl[bus.issue_rd] = bus.issue_tag;
            if (bus.flush_in)
                for (int i = 0; i < 32; i++) nl[i] = '0;
            m_regs = nr;
            m_lab  = nl;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        bus.issue_en   = 1'b0;
        bus.issue_rd   = '0;
        bus.issue_tag  = '0;
        bus.commit_en  = 1'b0;
        bus.commit_rd  = '0;
        bus.commit_res = '0;
        bus.commit_lab = '0;
        bus.flush_in   = 1'b0;
    endtask

    task automatic issue(int rd, int tag);
        bus.issue_en  = 1'b1;
        bus.issue_rd  = RW'(rd);
        bus.issue_tag = LW'(tag);
    endtask

    task automatic commit(int rd, int lab, logic [VW-1:0] res);
        bus.commit_en  = 1'b1;
        bus.commit_rd  = RW'(rd);
        bus.commit_lab = LW'(lab);
        bus.commit_res = res;
    endtask

    task automatic rd(int a, int b);
        bus.rs1 = RW'(a);
        bus.rs2 = RW'(b);
    endtask

    function automatic logic [VW+LW-1:0] mread(logic [RW-1:0] rs);
        if (rs == 0) return '0;
`ifdef RENAME_RF_BYPASS_EN
        if (bus.commit_en && bus.commit_rd == rs &&
            m_lab[rs] == bus.commit_lab)
            return {bus.commit_res, LW'(0)};
`endif
        return {m_regs[rs], m_lab[rs]};
    endfunction

    initial begin
        logic [VW+LW-1:0] r1;
        logic [VW+LW-1:0] r2;
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 'x;
            m_lab[i]  = 'x;
        end
        rst_in = 1'b1;
        rdy_in = 1'b1;
        idle();
        rd(0, 0);
        tick();
        tick();
        rst_in = 1'b0;

        rd(5, 0);
        exp2("reset", '0, '0, '0, '0);
        sample();

        issue(3, 2);
        tick();
        idle();
        rd(3, 0);
        exp2("issue", '0, 4'd2, '0, '0);
        sample();

        commit(3, 2, 32'hDEADBEEF);
        tick();
        idle();
        exp2("commit", 32'hDEADBEEF, '0, '0, '0);
        sample();

        issue(3, 2);
        tick();
        issue(3, 4);
        tick();
        idle();
        commit(3, 2, 32'd7);
        tick();
        idle();
        rd(3, 3);
        exp2("younger", 32'd7, 4'd4, 32'd7, 4'd4);
        sample();

        issue(6, 3);
        tick();
        idle();
        issue(6, 5);
        commit(6, 1, 32'd9);
        rd(6, 0);
        exp2("same_pre", '0, 4'd3, '0, '0);
        sample();
        tick();
        idle();
        exp2("same_post", 32'd9, 4'd5, '0, '0);
        sample();

        issue(1, 1);
        tick();
        issue(2, 2);
        tick();
        issue(7, 3);
        tick();
        idle();
        rd(1, 7);
        exp2("pend", '0, 4'd1, '0, 4'd3);
        sample();
        bus.flush_in = 1'b1;
        commit(2, 9, 32'h11);
        issue(8, 6);
        tick();
        idle();
        rd(1, 7);
        exp2("flush_a", '0, '0, '0, '0);
        sample();
        rd(2, 8);
        exp2("flush_b", 32'h11, '0, '0, '0);
        sample();

        issue(0, 5);
        commit(0, 0, 32'd5);
        tick();
        idle();
        rd(0, 0);
        exp2("x0", '0, '0, '0, '0);
        sample();

        issue(4, 3);
        tick();
        idle();
        commit(4, 3, 32'h55);
        rd(0, 4);
`ifdef RENAME_RF_BYPASS_EN
        exp2("bypass", '0, '0, 32'h55, '0);
`else
        exp2("bypass", '0, '0, '0, 4'd3);
`endif
        sample();
        tick();
        idle();
        exp2("bypass_post", '0, '0, 32'h55, '0);
        sample();

        rdy_in = 1'b0;
        issue(9, 7);
        commit(9, 0, 32'd1);
        tick();
        idle();
        rdy_in = 1'b1;
        rd(9, 4);
        exp2("rdy_low", '0, '0, 32'h55, '0);
        sample();

        issue(10, 5);
        tick();
        idle();
        commit(10, 3, 32'hABC);
        tick();
        idle();
        rd(10, 10);
        exp2("stale", 32'hABC, 4'd5, 32'hABC, 4'd5);
        sample();

        rdy_in = 1'b0;
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        rdy_in = 1'b1;
        rd(10, 3);
        exp2("rst_ovr", '0, '0, '0, '0);
        sample();

        for (int n = 0; n < 400; n++) begin
            rst_in = ($urandom_range(0, 99) == 0);
            rdy_in = ($urandom_range(0, 9) != 0);
            bus.issue_en   = $urandom_range(0, 1) == 1;
            bus.issue_rd   = RW'($urandom_range(0, 7));
            bus.issue_tag  = LW'($urandom_range(1, ROB_SIZE));
            bus.commit_en  = $urandom_range(0, 1) == 1;
            bus.commit_rd  = RW'($urandom_range(0, 7));
            bus.commit_res = $urandom;
            bus.commit_lab = ($urandom_range(0, 2) != 0) ?
                             m_lab[bus.commit_rd] :
                             LW'($urandom_range(0, ROB_SIZE));
            bus.flush_in   = ($urandom_range(0, 19) == 0);
            rd($urandom_range(0, 7), $urandom_range(0, 7));
            #1;
            r1 = mread(bus.rs1);
            r2 = mread(bus.rs2);
            exp2("rand", r1[VW+LW-1:LW], r1[LW-1:0],
                 r2[VW+LW-1:LW], r2[LW-1:0]);
            sample();
            tick();
        end

        chk("sb_drain", 64'(sbq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
